// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: data width,
// RISC-V load/store funct3 codes and the request FSM state encoding.
package dmem_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling for byte/half/word accesses: store byte
// enables and data replication, load extraction with sign/zero
// extension, misalignment and illegal funct3 detection.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic            we,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] wdata_aligned,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned,
    output logic            bad_funct3
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword out of the stored word.
    always_comb begin
        byte_s = 8'(rword >> {lane, 3'b000});
        half_s = 16'(rword >> {lane[1], 4'b0000});
    end

    // Decode funct3 into lane enables, aligned store data and load result.
    always_comb begin
        byte_en       = 4'b0000;
        wdata_aligned = '0;
        rdata_ext     = '0;
        misaligned    = 1'b0;
        bad_funct3    = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en       = 4'b0001 << lane;
                wdata_aligned = {4{wdata[7:0]}};
                rdata_ext     = {{24{byte_s[7]}}, byte_s};
            end
            F3_H: begin
                byte_en       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
                rdata_ext     = {{16{half_s[15]}}, half_s};
                misaligned    = lane[0];
            end
            F3_W: begin
                byte_en       = 4'b1111;
                wdata_aligned = wdata;
                rdata_ext     = rword;
                misaligned    = (lane != 2'b00);
            end
            F3_BU: begin
                if (we) begin
                    bad_funct3 = 1'b1;
                end else begin
                    rdata_ext = {24'h000000, byte_s};
                end
            end
            F3_HU: begin
                misaligned = lane[0];
                if (we) begin
                    bad_funct3 = 1'b1;
                end else begin
                    rdata_ext = {16'h0000, half_s};
                end
            end
            default: begin
                bad_funct3 = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store channel: accepts one
// request, waits LATENCY cycles, commits the access against an internal
// word array and holds the response until the initiator takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int         IW       = $clog2(DEPTH);
    localparam bit         HAS_WAIT = (LATENCY > 0);
    localparam logic [3:0] LAT_LOAD = HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

    logic [XLEN-1:0] mem [DEPTH];

    state_t          state_r, state_next_s;
    logic [3:0]      cnt_r, cnt_next_s;
    logic            accept_s, commit_s;
    logic            req_ready_r, resp_valid_r, resp_err_r;
    logic [XLEN-1:0] resp_rdata_r;

    logic            cap_we_r;
    logic [AW-1:0]   cap_addr_r;
    logic [XLEN-1:0] cap_wdata_r;
    logic [2:0]      cap_funct3_r;

    logic            cur_we_s;
    logic [AW-1:0]   cur_addr_s;
    logic [XLEN-1:0] cur_wdata_s;
    logic [2:0]      cur_funct3_s;

    logic [IW-1:0]   idx_s;
    logic            out_of_range_s, err_s;
    logic [3:0]      byte_en_s;
    logic [XLEN-1:0] wdata_al_s, rdata_ext_s;
    logic            misaligned_s, bad_funct3_s;

    // With zero latency the access commits on the accepting edge, so the
    // live request is used in IDLE and the captured one afterwards.
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s     = req_we;
            cur_addr_s   = req_addr;
            cur_wdata_s  = req_wdata;
            cur_funct3_s = req_funct3;
        end else begin
            cur_we_s     = cap_we_r;
            cur_addr_s   = cap_addr_r;
            cur_wdata_s  = cap_wdata_r;
            cur_funct3_s = cap_funct3_r;
        end
    end

    // Word index and range check of the current access.
    always_comb begin
        idx_s          = cur_addr_s[IW+1:2];
        out_of_range_s = |cur_addr_s[AW-1:IW+2];
        err_s          = out_of_range_s | misaligned_s | bad_funct3_s;
    end

    dmem_lane_align u_align (
        .we            (cur_we_s),
        .lane          (cur_addr_s[1:0]),
        .funct3        (cur_funct3_s),
        .wdata         (cur_wdata_s),
        .rword         (mem[idx_s]),
        .byte_en       (byte_en_s),
        .wdata_aligned (wdata_al_s),
        .rdata_ext     (rdata_ext_s),
        .misaligned    (misaligned_s),
        .bad_funct3    (bad_funct3_s)
    );

    // Next-state logic: IDLE -> WAIT (LATENCY cycles) -> RESP -> IDLE.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    if (HAS_WAIT) begin
                        state_next_s = WAIT;
                        cnt_next_s   = LAT_LOAD;
                    end else begin
                        state_next_s = RESP;
                        commit_s     = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                    commit_s     = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered handshake/response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            req_ready_r  <= (state_next_s == IDLE);
            resp_valid_r <= (state_next_s == RESP);
            if (commit_s) begin
                resp_err_r   <= err_s;
                resp_rdata_r <= (err_s || cur_we_s) ? '0 : rdata_ext_s;
            end else if (state_next_s == IDLE) begin
                resp_err_r   <= 1'b0;
                resp_rdata_r <= '0;
            end
        end
    end

    // Capture the request on acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we_r     <= 1'b0;
            cap_addr_r   <= '0;
            cap_wdata_r  <= '0;
            cap_funct3_r <= 3'b000;
        end else if (accept_s) begin
            cap_we_r     <= req_we;
            cap_addr_r   <= req_addr;
            cap_wdata_r  <= req_wdata;
            cap_funct3_r <= req_funct3;
        end
    end

    // Array write on the commit edge, only the addressed lanes, never on error.
    always_ff @(posedge clk) begin
        if (commit_s && cur_we_s && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_s[i]) begin
                    mem[idx_s][8*i +: 8] <= wdata_al_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a transaction-level memory model predicts
// acceptance, response timing and data; a per-cycle compare process
// checks DUT outputs against it, plus literal expectations. A second
// zero-latency instance is exercised with directed checks.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_resp_ready = 1'b1;
    logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0;
    logic [2:0]  b_req_funct3 = 3'b000;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A), .AW(32)) dut_a (
        .clk(clk), .reset(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0), .AW(32)) dut_b (
        .clk(clk), .reset(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_funct3(b_req_funct3),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem [int];
    int          cyc = 0;
    bit          pend = 1'b0, ready_ok = 1'b0;
    int          due = 0, acc_cyc = 0, acc_cnt = 0;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_err = 1'b0;
    bit          st_pend = 1'b0;
    int          st_idx = 0;
    logic [31:0] st_val = 32'h0;
    bit          t_acc, t_cmp, t_wr;

    function automatic void model_access(input bit we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [2:0] f3,
                                         output logic [31:0] rd, output bit err,
                                         output bit wr, output int widx, output logic [31:0] wval);
        int size; bit sgn; bit legal; int sh;
        logic [63:0] mask, word, val;
        legal = 1'b1; sgn = 1'b0; size = 4;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: begin size = 1; legal = !we; end
            3'd5: begin size = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        err  = !legal || ((addr % size) != 0) || (addr >= 32'(DEPTH * 4));
        widx = int'(addr / 4);
        word = mdl_mem.exists(widx) ? {32'h0, mdl_mem[widx]} : 64'h0;
        sh   = 8 * int'(addr % 4);
        mask = (64'd1 << (8 * size)) - 64'd1;
        rd = 32'h0; wr = 1'b0; wval = 32'h0;
        if (!err && !we) begin
            val = (word >> sh) & mask;
            if (sgn && val[8*size-1]) val = val | ~mask;
            rd = val[31:0];
        end
        if (!err && we) begin
            wr = 1'b1;
            val = (word & ~(mask << sh)) | (({32'h0, wdata} & mask) << sh);
            wval = val[31:0];
        end
    endfunction

    // Model tracker: acceptance, commit and completion seen at each edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            pend = 1'b0; ready_ok = 1'b0; st_pend = 1'b0;
        end else begin
            t_acc = req_valid && ready_ok && !pend;
            t_cmp = pend && (cyc >= due) && resp_ready;
            if (st_pend && cyc == due - 1) begin
                mdl_mem[st_idx] = st_val;
                st_pend = 1'b0;
            end
            if (t_cmp) pend = 1'b0;
            if (t_acc) begin
                model_access(req_we, req_addr, req_wdata, req_funct3,
                             exp_rdata, exp_err, t_wr, st_idx, st_val);
                st_pend = t_wr;
                pend = 1'b1;
                due = cyc + 1 + LAT_A;
                acc_cyc = cyc;
                acc_cnt++;
            end
            ready_ok = 1'b1;
        end
        cyc++;
    end

    // Compare process: DUT outputs against the model every cycle.
    logic [31:0] got_rdata = 32'h0;
    logic        got_err = 1'b0;
    int          first_v_cyc = -1, first_v_acc = -1;
    always @(negedge clk) begin
        if (!reset_n) begin
            chk32("reset_outputs", {req_ready, resp_valid, resp_err, resp_rdata[28:0]} | {3'b000, resp_rdata[31:29], 26'h0}, 32'h0);
        end else begin
            chk32("req_ready", {31'h0, req_ready}, {31'h0, (ready_ok && !pend)});
            chk32("resp_valid", {31'h0, resp_valid}, {31'h0, (pend && cyc >= due)});
            if (pend && cyc >= due) begin
                chk32("resp_rdata", resp_rdata, exp_rdata);
                chk32("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
                got_rdata = resp_rdata;
                got_err   = resp_err;
                if (resp_valid && first_v_acc != acc_cnt) begin
                    first_v_acc = acc_cnt;
                    first_v_cyc = cyc;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
        int start;
        @(posedge clk); #1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
        start = acc_cnt;
        for (int i = 0; i < 40 && acc_cnt == start; i++) begin
            @(posedge clk); #1;
        end
        if (acc_cnt == start) begin
            checks++; errors++;
            $display("FAIL accept_timeout got=none exp=accepted");
        end
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    endtask

    task automatic finish_txn();
        for (int i = 0; i < 60 && pend; i++) begin
            @(posedge clk); #1;
        end
        if (pend) begin
            checks++; errors++;
            $display("FAIL resp_timeout got=pending exp=done");
        end
    endtask

    task automatic xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
        issue(we, addr, wdata, f3);
        finish_txn();
    endtask

    task automatic load_chk(input string name, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] exp);
        xfer(1'b0, addr, 32'h0, f3);
        chk32(name, got_rdata, exp);
        chk32({name, "_model"}, exp_rdata, exp);
        chk32({name, "_err"}, {31'h0, got_err}, 32'h0);
    endtask

    task automatic err_chk(input string name, input bit we, input logic [31:0] addr, input logic [2:0] f3);
        xfer(we, addr, 32'hFFFF_FFFF, f3);
        chk32({name, "_err"}, {31'h0, got_err}, 32'h1);
        chk32({name, "_rdata"}, got_rdata, 32'h0);
    endtask

    task automatic b_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                          output logic [31:0] rd, output logic err);
        bit was_ready, done;
        done = 1'b0; rd = 32'h0; err = 1'b0;
        @(posedge clk); #1;
        b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_funct3 = f3; b_req_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk); was_ready = b_req_ready;
            @(posedge clk); #1;
            if (was_ready) begin
                done = 1'b1;
                b_req_valid = 1'b0;
                chk32("b_resp_valid_t1", {31'h0, b_resp_valid}, 32'h1);
                rd = b_resp_rdata; err = b_resp_err;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL b_accept_timeout got=none exp=accepted");
        end
        @(posedge clk); #1;
        chk32("b_resp_valid_drop", {31'h0, b_resp_valid}, 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a1, a2;
        logic [31:0] brd;
        logic        berr;
        #1 reset_n = 1'b0;
        #2;
        chk32("reset_req_ready", {31'h0, req_ready}, 32'h0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // store then load, latency T+3
        issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        a1 = acc_cyc;
        finish_txn();
        chk32("sw_latency", 32'(first_v_cyc - a1), 32'd3);
        chk32("sw_err", {31'h0, got_err}, 32'h0);
        chk32("sw_rdata", got_rdata, 32'h0);
        load_chk("lw_10", 32'h10, 3'b010, 32'hDEADBEEF);
        load_chk("lb_13", 32'h13, 3'b000, 32'hFFFFFFDE);
        load_chk("lbu_13", 32'h13, 3'b100, 32'h000000DE);
        load_chk("lh_12", 32'h12, 3'b001, 32'hFFFFDEAD);
        load_chk("lhu_10", 32'h10, 3'b101, 32'h0000BEEF);

        // partial stores
        xfer(1'b1, 32'h11, 32'h00000055, 3'b000);
        load_chk("lw_after_sb", 32'h10, 3'b010, 32'hDEAD55EF);
        xfer(1'b1, 32'h12, 32'h00001234, 3'b001);
        load_chk("lw_after_sh", 32'h10, 3'b010, 32'h123455EF);

        // errors
        err_chk("lw_mis", 1'b0, 32'h11, 3'b010);
        err_chk("sh_mis", 1'b1, 32'h13, 3'b001);
        err_chk("lw_oor", 1'b0, 32'(DEPTH * 4), 3'b010);
        err_chk("ld_badf3", 1'b0, 32'h10, 3'b011);
        err_chk("st_badf3", 1'b1, 32'h10, 3'b100);
        load_chk("lw_unchanged", 32'h10, 3'b010, 32'h123455EF);

        // back-to-back with req_valid held high
        @(posedge clk); #1;
        req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
        a1 = acc_cnt;
        for (int i = 0; i < 20 && acc_cnt == a1; i++) begin @(posedge clk); #1; end
        a1 = acc_cyc;
        req_addr = 32'h13; req_funct3 = 3'b100;
        a2 = acc_cnt;
        for (int i = 0; i < 20 && acc_cnt == a2; i++) begin @(posedge clk); #1; end
        a2 = acc_cyc;
        req_valid = 1'b0;
        finish_txn();
        chk32("b2b_spacing", 32'(a2 - a1), 32'(LAT_A + 2));
        chk32("b2b_lbu", got_rdata, 32'h00000012);

        // backpressure
        resp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        for (int i = 0; i < 20 && cyc < due; i++) begin @(posedge clk); #1; end
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
        finish_txn();
        chk32("bp_rdata", got_rdata, 32'h123455EF);

        // reset during WAIT discards a captured store
        xfer(1'b1, 32'h20, 32'h11111111, 3'b010);
        issue(1'b1, 32'h20, 32'hCAFEF00D, 3'b010);
        #1 reset_n = 1'b0;
        #1;
        chk32("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk32("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk32("rst_resp_rdata", resp_rdata, 32'h0);
        chk32("rst_resp_err", {31'h0, resp_err}, 32'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        load_chk("lw_20_after_rst", 32'h20, 3'b010, 32'h11111111);

        // zero-latency instance
        b_xfer(1'b1, 32'h40, 32'hA5A5A5A5, 3'b010, brd, berr);
        chk32("b_sw_err", {31'h0, berr}, 32'h0);
        chk32("b_sw_rdata", brd, 32'h0);
        b_xfer(1'b0, 32'h40, 32'h0, 3'b010, brd, berr);
        chk32("b_lw_rdata", brd, 32'hA5A5A5A5);
        b_xfer(1'b0, 32'h42, 32'h0, 3'b101, brd, berr);
        chk32("b_lhu_rdata", brd, 32'h0000A5A5);
        b_xfer(1'b0, 32'h41, 32'h0, 3'b001, brd, berr);
        chk32("b_lh_mis_err", {31'h0, berr}, 32'h1);
        chk32("b_lh_mis_rdata", brd, 32'h0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the core's load/store request channel.
- Accepts one load/store request at a time over a valid/ready handshake.
- Performs the RISC-V byte/half/word access against an internal word array, after a programmable number of wait states.
- Returns read data or an error flag over a valid/ready response channel. Sits beside the execute stage; the core's memory stage is the initiator.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; must be a power of two.
- LATENCY, 2, wait-state cycles between request acceptance and response; 0..15.
- AW, 32, width of the byte address.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_funct3  in  3  RISC-V load/store funct3.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; req_ready=0 while reset is asserted, 1 from the first clock edge after release.
  - resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Array contents are not reset.
- FSM IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: req_ready=1. When req_valid&&req_ready at edge T, capture we/addr/wdata/funct3. Go to WAIT if LATENCY>0 (counter loaded with LATENCY-1), else RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0 go to RESP.
  - Access commits on the edge entering RESP: store writes the array, load registers resp_rdata.
  - RESP: resp_valid=1 is first visible in cycle T+1+LATENCY. resp_valid, resp_rdata and resp_err hold stable until resp_valid&&resp_ready, then go to IDLE with resp_valid=0 next cycle.
- Back-to-back limits: one outstanding request only. No new request is accepted in the same cycle a response completes. Minimum request spacing is LATENCY+2 cycles.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other value sets err.
  - Stores: 000 SB, 001 SH, 010 SW; any other value sets err.
- Data alignment and extension:
  - Word index = addr[log2(DEPTH)+1:2].
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores write only the addressed lanes; the other lanes keep their values.
- Errors:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr >= DEPTH*4.
  - On error: no array write, resp_rdata=0, resp_err=1. The response still follows the normal latency.
- Reset mid-operation: returns to IDLE. A captured store not yet committed is discarded. A response in progress is dropped with resp_valid=0.
- Inputs are ignored outside the IDLE acceptance cycle; changing them during WAIT/RESP has no effect.

Decomposition:
- Shared core package holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding IDLE/WAIT/RESP;
  - the 32-bit data-width constant.
- One natural sub-module, dmem_lane_align. It is combinational and handles:
  - store byte-enable and data shifting;
  - load extraction with sign/zero extension;
  - the misalignment check.
- The FSM, wait counter and array stay in dmem_responder.

Test Plan:
- LATENCY=2, SW 0xDEADBEEF to 0x10 accepted at T -> resp_valid at T+3, err=0. A following LW 0x10 returns 0xDEADBEEF.
- With 0xDEADBEEF at word 0x10:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
- SB 0x55 to 0x11 over 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF. SH 0x1234 to 0x12 -> 0x123455EF.
- LW at 0x11, SH at 0x13, and LW at DEPTH*4 -> each gets resp_err=1 and rdata=0. A following LW 0x10 shows the array unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable and req_ready=0 throughout. Response completes on the cycle resp_ready=1.
- Assert reset during WAIT of a SW 0xCAFEF00D to 0x20 (old 0x11111111) -> outputs zero immediately; after release, LW 0x20 returns 0x11111111. Also run with LATENCY=0: response at T+1.
